fifo_burst_reader: RTL and testbench



---
 rtl/fifo_burst_reader_pkg.sv | 7 +
 rtl/fifo_burst_reader_if.sv | 26 ++
 rtl/fifo_burst_reader_skid_buf2.sv | 37 +++
 rtl/fifo_burst_reader.sv | 54 +++++
 tb/tb_fifo_burst_reader.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// fifo_rd_pkg: shared FSM encoding and skid depth for the burst reader
package fifo_rd_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: FIFO read port, burst command and output stream bundle
// master = the burst reader, slave = FIFO/command source/stream sink side
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH = 8
);
  logic Fifo_empty_in;
  logic [DATA_WIDTH-1:0] Fifo_data_in;
  logic Fifo_read_en_out;
  logic Burst_start_in;
  logic [LEN_WIDTH-1:0] Burst_len_in;
  logic Burst_busy_out;
  logic Burst_done_out;
  logic M_valid_out;
  logic [DATA_WIDTH-1:0] M_data_out;
  logic M_ready_in;
  logic [LEN_WIDTH-1:0] Word_cnt_out;
  modport master (
    input Fifo_empty_in, Fifo_data_in, Burst_start_in, Burst_len_in, M_ready_in,
    output Fifo_read_en_out, Burst_busy_out, Burst_done_out, M_valid_out, M_data_out, Word_cnt_out
  );
  modport slave (
    output Fifo_empty_in, Fifo_data_in, Burst_start_in, Burst_len_in, M_ready_in,
    input Fifo_read_en_out, Burst_busy_out, Burst_done_out, M_valid_out, M_data_out, Word_cnt_out
  );
endinterface

// File: rtl/fifo_burst_reader_skid_buf2.sv
// skid_buf2: 2-entry valid/ready buffer; e0 is the head, occ reports fill level
// ports: clk, rst_n (async low), in_valid/in_data (capture, no backpressure),
//        out_valid/out_data/out_ready (stream), occ (0..2)
module skid_buf2 import fifo_rd_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            occ
);
  logic [DATA_WIDTH-1:0] e0, e1;
  logic pop;
  logic [1:0] wpos;
  always_comb begin
    out_valid = occ != 2'd0;
    out_data = e0;
    pop = out_valid && out_ready;
    wpos = occ - {1'b0, pop};
  end
  // caller guarantees no capture into a full buffer that is not draining
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      occ <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      if (pop && occ == 2'(SKID_DEPTH)) e0 <= e1;
      if (in_valid && wpos == 2'd0) e0 <= in_data;
      if (in_valid && wpos == 2'd1) e1 <= in_data;
      occ <= occ + {1'b0, in_valid} - {1'b0, pop};
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a counted burst from the FIFO and streams it via a skid buffer
// ports: RClk, Rst_n (async low), bus (master side of fifo_burst_reader_if)
module fifo_burst_reader import fifo_rd_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH = 8
) (
  input logic RClk,
  input logic Rst_n,
  fifo_burst_reader_if.master bus
);
  logic [1:0] state, occ;
  logic [LEN_WIDTH-1:0] len, issued, word_cnt;
  logic inflight, xfer;
  // credit counts the slot freed by a transfer this cycle, which keeps 1 word/cycle with ready high
  always_comb begin
    xfer = bus.M_valid_out && bus.M_ready_in;
    bus.Fifo_read_en_out = state == RUN && issued < len && !bus.Fifo_empty_in &&
                           (occ - {1'b0, xfer} + {1'b0, inflight}) < 2'd2;
    bus.Burst_busy_out = state == RUN;
    bus.Burst_done_out = state == DONE;
    bus.Word_cnt_out = word_cnt;
  end
  // a zero-length burst spends one cycle in RUN, placing its done pulse two cycles after the strobe
  always_ff @(posedge RClk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      len <= '0;
      issued <= '0;
      word_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= bus.Fifo_read_en_out;
      if (bus.Fifo_read_en_out) issued <= issued + 1'b1;
      if (xfer) word_cnt <= word_cnt + 1'b1;
      if (state == IDLE && bus.Burst_start_in) begin
        len <= bus.Burst_len_in;
        issued <= '0;
        word_cnt <= '0;
        state <= RUN;
      end
      if (state == RUN && (len == '0 || (xfer && word_cnt + 1'b1 == len))) state <= DONE;
      if (state == DONE) state <= IDLE;
    end
  skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk(RClk),
    .rst_n(Rst_n),
    .in_valid(inflight),
    .in_data(bus.Fifo_data_in),
    .out_valid(bus.M_valid_out),
    .out_data(bus.M_data_out),
    .out_ready(bus.M_ready_in),
    .occ(occ)
  );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scoreboard bench with a queue-based FIFO model and stream monitor
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int LW = 8;
  logic RClk = 1'b0;
  logic Rst_n = 1'b0;
  fifo_burst_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bif ();
  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (.RClk(RClk), .Rst_n(Rst_n), .bus(bif));
  always #5 RClk = ~RClk;
  int total = 0, bad = 0;
  logic [DW-1:0] fq[$], exp_q[$];
  int xc[$];
  int cyc = 0, pops = 0, dones = 0, xfers = 0, rd_hi = 0, done_cyc = -1, cur_len = 0, s_cyc = 0;
  logic hold_prev = 1'b0, prev_done = 1'b0;
  logic [DW-1:0] prev_data = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask
  // FIFO model: pop when read enable meets non-empty, word appears on the next cycle
  always @(posedge RClk) begin
    cyc++;
    if (bif.Fifo_read_en_out && !bif.Fifo_empty_in && fq.size() != 0) begin
      bif.Fifo_data_in <= fq.pop_front();
      pops++;
    end
    bif.Fifo_empty_in <= (fq.size() == 0);
  end
  // monitor: compares every stream transfer against the scoreboard queue
  always @(negedge RClk) begin
    if (!Rst_n) begin
      hold_prev = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bif.Fifo_read_en_out) begin
        rd_hi++;
        chk("rd_en_while_empty", bif.Fifo_empty_in, 0);
      end
      if (hold_prev) begin
        chk("hold_valid", bif.M_valid_out, 1);
        chk("hold_data", bif.M_data_out, prev_data);
      end
      if (bif.M_valid_out && bif.M_ready_in) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0d want none", bif.M_data_out);
        end else chk("stream_data", bif.M_data_out, exp_q.pop_front());
        xc.push_back(cyc);
        xfers++;
      end
      if (bif.Burst_done_out) begin
        dones++;
        done_cyc = cyc;
        chk("done_word_cnt", bif.Word_cnt_out, cur_len);
        chk("done_words_left", exp_q.size(), 0);
        chk("done_width", prev_done, 0);
      end
      hold_prev = bif.M_valid_out && !bif.M_ready_in;
      prev_data = bif.M_data_out;
      prev_done = bif.Burst_done_out;
    end
  end
  task automatic load(input int n);
    logic [DW-1:0] w;
    for (int j = 0; j < n; j++) begin
      w = DW'($urandom);
      fq.push_back(w);
      exp_q.push_back(w);
    end
  endtask
  // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random
  task automatic run(input string nm, input int len, input int rmode, input int push_at,
                     input int ign_at, input int gap_at);
    int d0, x0, busy_lo;
    d0 = dones;
    x0 = xfers;
    busy_lo = 0;
    xc.delete();
    @(posedge RClk);
    #1;
    bif.Burst_start_in = 1'b1;
    bif.Burst_len_in = LW'(len);
    bif.M_ready_in = (rmode != 1);
    cur_len = len;
    s_cyc = cyc;
    for (int i = 0; i < 400; i++) begin
      @(posedge RClk);
      #1;
      if (dones != d0) break;
      bif.Burst_start_in = (i == ign_at);
      bif.Burst_len_in = (i == ign_at) ? LW'(2) : LW'(len);
      bif.M_ready_in = rmode == 0 ? 1'b1 : rmode == 1 ? (i % 4 == 3 || i % 4 == 2) : 1'($urandom_range(0, 1));
      if (i == push_at) load(4);
      if (i == gap_at) chk({nm, "_valid_gap"}, bif.M_valid_out, 0);
      if (!bif.Burst_busy_out && !bif.Burst_done_out) busy_lo++;
    end
    chk({nm, "_done_seen"}, dones - d0, 1);
    chk({nm, "_busy_held"}, busy_lo, 0);
    chk({nm, "_words"}, xfers - x0, len);
    bif.Burst_start_in = 1'b0;
    repeat (3) @(posedge RClk);
    #1;
    chk({nm, "_single_done"}, dones - d0, 1);
  endtask
  initial begin
    logic [DW-1:0] t1[5];
    int p0, r0;
    t1 = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd4};
    bif.Burst_start_in = 1'b0;
    bif.Burst_len_in = '0;
    bif.M_ready_in = 1'b0;
    repeat (3) @(posedge RClk);
    #1;
    chk("rst_rd_en", bif.Fifo_read_en_out, 0);
    chk("rst_busy", bif.Burst_busy_out, 0);
    chk("rst_done", bif.Burst_done_out, 0);
    chk("rst_valid", bif.M_valid_out, 0);
    chk("rst_data", bif.M_data_out, 0);
    chk("rst_word_cnt", bif.Word_cnt_out, 0);
    Rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      fq.push_back(t1[j]);
      exp_q.push_back(t1[j]);
    end
    repeat (2) @(posedge RClk);
    p0 = pops;
    run("t1", 5, 0, -1, -1, -1);
    chk("t1_pops", pops - p0, 5);
    chk("t1_xfers_back_to_back", xc[4] - xc[0], 4);
    chk("t1_done_after_last", done_cyc - xc[4], 1);
    chk("t1_word_cnt_hold", bif.Word_cnt_out, 5);
    load(10);
    repeat (2) @(posedge RClk);
    run("t2", 10, 1, -1, -1, -1);
    load(4);
    repeat (2) @(posedge RClk);
    run("t3", 8, 0, 20, -1, 15);
    r0 = rd_hi;
    run("t4", 0, 0, -1, -1, -1);
    chk("t4_no_read", rd_hi - r0, 0);
    chk("t4_done_at_start_plus_2", done_cyc - s_cyc, 2);
    chk("t4_word_cnt", bif.Word_cnt_out, 0);
    load(6);
    repeat (2) @(posedge RClk);
    run("t5", 6, 1, -1, 3, -1);
    load(4);
    repeat (2) @(posedge RClk);
    @(posedge RClk);
    #1;
    bif.M_ready_in = 1'b0;
    bif.Burst_start_in = 1'b1;
    bif.Burst_len_in = LW'(4);
    cur_len = 4;
    @(posedge RClk);
    #1;
    bif.Burst_start_in = 1'b0;
    repeat (6) @(posedge RClk);
    #3;
    chk("t6_pre_valid", bif.M_valid_out, 1);
    chk("t6_pre_busy", bif.Burst_busy_out, 1);
    Rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bif.M_valid_out, 0);
    chk("t6_rst_busy", bif.Burst_busy_out, 0);
    chk("t6_rst_rd_en", bif.Fifo_read_en_out, 0);
    chk("t6_rst_word_cnt", bif.Word_cnt_out, 0);
    fq.delete();
    exp_q.delete();
    @(posedge RClk);
    #1;
    Rst_n = 1'b1;
    load(3);
    repeat (2) @(posedge RClk);
    run("t6_after", 3, 0, -1, -1, -1);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 12);
      load(n);
      repeat (2) @(posedge RClk);
      run("rnd", n, 2, -1, -1, -1);
    end
    chk("final_fifo_empty", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
